// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Single-clock sequencer for the stopwatch BCD counter/display datapath.
// It conditions the clear (R) and start/pause (P) buttons and runs the
// CLEAR/RUN/PAUSE/DONE control FSM. It also produces the count-tick enable,
// the counter clear request, the latched mode/preload and the display digit
// scan select. The downstream counter and display mux therefore need no
// second clock.
//
// Parameters
//   TICK_DIV : c_clk cycles per count tick (>= 2)
//   SCAN_DIV : c_clk cycles per display digit step (>= 2)
//
// Ports
//   c_clk    in   system clock, all state moves on the rising edge
//   R_n      in   asynchronous active-low reset
//   R        in   clear button, active high, asynchronous to c_clk
//   P        in   start/pause button, active high, asynchronous to c_clk
//   sel[1:0] in   mode: 0 up from 00.00, 1 up from preload,
//                       2 down from 99.99, 3 down from preload
//   load[7:0] in  preload BCD digits {tens, units}
//   C[15:0]  in   current BCD count fed back from the counter
//   cnt_clr  out  counter clear/preload request (level, high in CLEAR)
//   cnt_en   out  one-cycle count enable
//   mode     out  sel latched while in CLEAR
//   load_q   out  load latched while in CLEAR
//   scan_sel out  digit index being driven, stepping 0,3,2,1,0...
//   running  out  high in RUN
//   done     out  high in DONE
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        c_clk,
  input  logic        R_n,
  input  logic        R,
  input  logic        P,
  input  logic [1:0]  sel,
  input  logic [7:0]  load,
  input  logic [15:0] C,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic [1:0]  mode,
  output logic [7:0]  load_q,
  output logic [1:0]  scan_sel,
  output logic        running,
  output logic        done
);

  localparam int TDW = $clog2(TICK_DIV);
  localparam int SDW = $clog2(SCAN_DIV);
  localparam logic [TDW-1:0] TDIV_MAX = TDW'(TICK_DIV - 1);
  localparam logic [SDW-1:0] SDIV_MAX = SDW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: two-flop synchronizers, plus an edge register on P
  // so a held P yields exactly one pulse.
  // ---------------------------------------------------------------------------
  logic r_meta_q, r_s_q;
  logic p_meta_q, p_s_q, p_s_d_q;
  logic p_pulse;

  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      r_meta_q <= 1'b0;
      r_s_q    <= 1'b0;
      p_meta_q <= 1'b0;
      p_s_q    <= 1'b0;
      p_s_d_q  <= 1'b0;
    end else begin
      r_meta_q <= R;
      r_s_q    <= r_meta_q;
      p_meta_q <= P;
      p_s_q    <= p_meta_q;
      p_s_d_q  <= p_s_q;
    end
  end

  assign p_pulse = p_s_q & ~p_s_d_q;

  // ---------------------------------------------------------------------------
  // Mode / preload latch: transparent each cycle in CLEAR, frozen otherwise,
  // so a sel change mid-run only takes effect after the next clear.
  // ---------------------------------------------------------------------------
  logic [1:0] mode_q;
  logic [7:0] load_lat_q;
  state_t     state_q, state_d;

  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      mode_q     <= 2'd0;
      load_lat_q <= 8'd0;
    end else if (state_q == S_CLEAR) begin
      mode_q     <= sel;
      load_lat_q <= load;
    end
  end

  // Up modes stop at 99.99, down modes stop at 00.00.
  logic terminal;
  assign terminal = mode_q[1] ? (C == 16'h0000) : (C == 16'h9999);

  // ---------------------------------------------------------------------------
  // Control FSM. Clear has priority over start/pause everywhere. When the
  // terminal count and a P pulse land together in RUN, PAUSE wins; terminal
  // is looked at again on the first RUN cycle after resume.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR: begin
        if (!r_s_q && p_pulse) state_d = S_RUN;
      end
      S_RUN: begin
        if (r_s_q)         state_d = S_CLEAR;
        else if (p_pulse)  state_d = S_PAUSE;
        else if (terminal) state_d = S_DONE;
      end
      S_PAUSE: begin
        if (r_s_q)        state_d = S_CLEAR;
        else if (p_pulse) state_d = S_RUN;
      end
      S_DONE: begin
        if (r_s_q) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State and its decoded flags are registered together so the outputs come
  // straight from flops.
  logic clr_q, run_q, done_q;

  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      state_q <= S_CLEAR;
      clr_q   <= 1'b1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= (state_d == S_CLEAR);
      run_q   <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Tick prescaler. Holding in PAUSE/DONE keeps the fractional tick, so a
  // pause/resume does not lose or gain time.
  // ---------------------------------------------------------------------------
  logic [TDW-1:0] tdiv_q;

  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      tdiv_q <= '0;
    end else begin
      unique case (state_q)
        S_CLEAR: tdiv_q <= '0;
        S_RUN:   tdiv_q <= (tdiv_q == TDIV_MAX) ? '0 : tdiv_q + TDW'(1);
        default: tdiv_q <= tdiv_q;
      endcase
    end
  end

  // Suppressed at terminal so the count never runs past 99.99 / 00.00.
  assign cnt_en = run_q && (tdiv_q == TDIV_MAX) && !terminal;

  // ---------------------------------------------------------------------------
  // Display scan: free-running in every state, digit index counts down.
  // ---------------------------------------------------------------------------
  logic [SDW-1:0] scnt_q;
  logic [1:0]     scan_sel_q;

  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      scnt_q     <= '0;
      scan_sel_q <= 2'd0;
    end else if (scnt_q == SDIV_MAX) begin
      scnt_q     <= '0;
      scan_sel_q <= scan_sel_q - 2'd1;
    end else begin
      scnt_q     <= scnt_q + SDW'(1);
    end
  end

  assign cnt_clr  = clr_q;
  assign running  = run_q;
  assign done     = done_q;
  assign mode     = mode_q;
  assign load_q   = load_lat_q;
  assign scan_sel = scan_sel_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a cycle-level behavioural model of the stopwatch controller.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  localparam int M_CLEAR = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        c_clk = 1'b0;
  logic        R_n   = 1'b1;
  logic        R     = 1'b0;
  logic        P     = 1'b0;
  logic [1:0]  sel   = 2'd0;
  logic [7:0]  load  = 8'd0;
  logic [15:0] C     = 16'h1234;
  logic        cnt_clr, cnt_en, running, done;
  logic [1:0]  mode, scan_sel;
  logic [7:0]  load_q;

  stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .c_clk   (c_clk),
    .R_n     (R_n),
    .R       (R),
    .P       (P),
    .sel     (sel),
    .load    (load),
    .C       (C),
    .cnt_clr (cnt_clr),
    .cnt_en  (cnt_en),
    .mode    (mode),
    .load_q  (load_q),
    .scan_sel(scan_sel),
    .running (running),
    .done    (done)
  );

  always #5 c_clk = ~c_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_state;
  int         m_phase;   // cycles into the current tick period
  int         m_edges;   // clock edges since reset release
  logic [1:0] m_mode;
  logic [7:0] m_load;
  bit   [2:0] r_hist;    // [0]=sample one edge ago, [1]=two ago, [2]=three ago
  bit   [2:0] p_hist;

  function automatic bit is_term(input logic [1:0] md, input logic [15:0] c);
    return md[1] ? (c == 16'h0000) : (c == 16'h9999);
  endfunction

  task automatic model_reset();
    m_state = M_CLEAR;
    m_phase = 0;
    m_edges = 0;
    m_mode  = 2'd0;
    m_load  = 8'd0;
    r_hist  = 3'b000;
    p_hist  = 3'b000;
  endtask

  task automatic model_edge();
    bit rs, pp, tm;
    int nxt;
    if (!R_n) return;
    rs  = r_hist[1];
    pp  = p_hist[1] & ~p_hist[2];
    tm  = is_term(m_mode, C);
    nxt = m_state;
    case (m_state)
      M_CLEAR: if (!rs && pp) nxt = M_RUN;
      M_RUN:   if (rs) nxt = M_CLEAR; else if (pp) nxt = M_PAUSE; else if (tm) nxt = M_DONE;
      M_PAUSE: if (rs) nxt = M_CLEAR; else if (pp) nxt = M_RUN;
      default: if (rs) nxt = M_CLEAR;
    endcase
    if (m_state == M_CLEAR) begin
      m_mode  = sel;
      m_load  = load;
      m_phase = 0;
    end else if (m_state == M_RUN) begin
      m_phase = (m_phase + 1) % TICK_DIV;
    end
    m_state = nxt;
    m_edges++;
    r_hist = {r_hist[1:0], R};
    p_hist = {p_hist[1:0], P};
  endtask

  task automatic check_all(input string ph);
    bit         exp_en;
    logic [1:0] exp_scan;
    exp_en   = (m_state == M_RUN) && (m_phase == TICK_DIV - 1) && !is_term(m_mode, C);
    exp_scan = 2'((4 - ((m_edges / SCAN_DIV) % 4)) % 4);
    check({ph, ".cnt_clr"},  16'(cnt_clr),  16'(m_state == M_CLEAR));
    check({ph, ".running"},  16'(running),  16'(m_state == M_RUN));
    check({ph, ".done"},     16'(done),     16'(m_state == M_DONE));
    check({ph, ".cnt_en"},   16'(cnt_en),   16'(exp_en));
    check({ph, ".mode"},     16'(mode),     16'(m_mode));
    check({ph, ".load_q"},   16'(load_q),   16'(m_load));
    check({ph, ".scan_sel"}, 16'(scan_sel), 16'(exp_scan));
  endtask

  task automatic cycle(input string ph, input int n);
    repeat (n) begin
      @(posedge c_clk);
      model_edge();
      @(negedge c_clk);
      check_all(ph);
    end
  endtask

  // Called on a falling edge: reset mid-cycle, check outputs before any
  // clock edge, release on the next falling edge.
  task automatic async_reset(input string ph);
    #2 R_n = 1'b0;
    #1 model_reset();
    check_all({ph, ".async"});
    @(negedge c_clk);
    R_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rnd;
    model_reset();
    #1 R_n = 1'b0;
    #2 check_all("reset");
    @(negedge c_clk);
    R_n = 1'b1;

    // Start in mode 0, then let a few ticks go by.
    sel = 2'd0;
    P = 1'b1; cycle("start", 3);
    P = 1'b0; cycle("run", 12);

    // Pause, hold, resume.
    P = 1'b1; cycle("pause", 2);
    P = 1'b0; cycle("paused", 6);
    P = 1'b1; cycle("resume", 2);
    P = 1'b0; cycle("resumed", 9);

    // Terminal in mode 0, then P is ignored in DONE, then clear.
    C = 16'h9999; cycle("term_up", 3);
    P = 1'b1; cycle("done_p", 3);
    P = 1'b0; cycle("done_hold", 3);
    C = 16'h1234; cycle("done_hold2", 2);
    R = 1'b1; cycle("clear", 2);
    R = 1'b0; cycle("cleared", 4);

    // Mode 3 with preload; sel/load change mid-run must not leak through.
    sel = 2'd3; load = 8'h25; C = 16'h2500; cycle("preload", 3);
    P = 1'b1; cycle("start3", 2);
    P = 1'b0; cycle("run3", 4);
    sel = 2'd0; load = 8'h99; cycle("selchg", 6);
    C = 16'h0000; cycle("term_dn", 3);
    R = 1'b1; cycle("clear3", 2);
    R = 1'b0; C = 16'h1234; cycle("cleared3", 4);

    // R and P together in RUN: clear wins.
    P = 1'b1; cycle("start5", 2);
    P = 1'b0; cycle("run5", 6);
    R = 1'b1; P = 1'b1; cycle("rp", 2);
    R = 1'b0; P = 1'b0; cycle("rp_after", 5);

    // Asynchronous reset in the middle of RUN.
    P = 1'b1; cycle("start6", 2);
    P = 1'b0; cycle("run6", 6);
    async_reset("run6");
    cycle("post_rst", 6);

    // Randomized phase.
    repeat (600) begin
      R = ($urandom_range(0, 24) == 0);
      P = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) begin
        sel  = 2'($urandom);
        load = 8'($urandom);
      end
      rnd = $urandom_range(0, 11);
      if (rnd == 0)      C = 16'h9999;
      else if (rnd == 1) C = 16'h0000;
      else if (rnd < 6)  C = 16'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset("rand");
      cycle("rand", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Single-clock sequencer for the stopwatch BCD counter/display datapath.
- Conditions the R (clear) and P (start/pause) buttons and runs the CLEAR/RUN/PAUSE/DONE control FSM.
- Generates the count-tick enable, the counter clear and the latched mode/preload.
- Generates the 4-digit display scan select. The counter and display mux then need no second clock.

Parameters:
TICK_DIV, 1000000, c_clk cycles per count tick (100 MHz -> 10 ms); must be >= 2.
SCAN_DIV, 100000, c_clk cycles per display digit step; must be >= 2.

Ports:
c_clk  input  1  system clock; all state updates on rising edge.
R_n  input  1  asynchronous active-low reset.
R  input  1  clear button, active high, asynchronous to c_clk.
P  input  1  start/pause button, active high, asynchronous to c_clk.
sel  input  2  mode: 0 up from 00.00, 1 up from preload, 2 down from 99.99, 3 down from preload.
load  input  8  preload BCD digits {tens, units}, placed in C[15:8].
C  input  16  current BCD count from the counter.
cnt_clr  output  1  counter clear/preload request, level.
cnt_en  output  1  one-cycle count enable.
mode  output  2  latched sel.
load_q  output  8  latched load.
scan_sel  output  2  digit index currently driven: 3,2,1,0 repeating.
running  output  1  high in RUN.
done  output  1  high in DONE.

Behaviour:
- Reset (R_n low, async):
  - state=CLEAR.
  - Synchronizers, edge register, both prescalers, mode, load_q and scan_sel are 0.
  - Outputs: cnt_clr=1, cnt_en=0, running=0, done=0.
- Input conditioning:
  - R and P each pass through a 2-flop synchronizer (r_s, p_s).
  - p_pulse = p_s & ~p_s_d, where p_s_d is p_s delayed one cycle.
  - P held high produces exactly one pulse. P high for 1 cycle is not guaranteed to be seen; P high for >= 2 cycles is.
  - r_s is used as a level.
- State encoding is the designer's choice.
- FSM: r_s has priority over p_pulse in every state.
  - CLEAR: if r_s, stay; else if p_pulse, go to RUN; else stay.
  - RUN: if r_s, go to CLEAR; else if p_pulse, go to PAUSE; else if the terminal condition holds, go to DONE.
  - PAUSE: if r_s, go to CLEAR; else if p_pulse, go to RUN.
  - DONE: if r_s, go to CLEAR; P is ignored.
- Terminal condition:
  - (mode[1]==0 && C==16'h9999) || (mode[1]==1 && C==16'h0000).
  - Evaluated only in RUN.
- Outputs by state (all decoded from the registered state):
  - cnt_clr = (state==CLEAR).
  - running = (state==RUN).
  - done = (state==DONE).
- Latching:
  - mode and load_q are loaded from sel/load every cycle while in CLEAR.
  - They are frozen in RUN, PAUSE and DONE.
  - A change of sel mid-run has no effect until the next clear.
- Tick prescaler tdiv, width ceil(log2(TICK_DIV)):
  - CLEAR: tdiv=0.
  - RUN: tdiv increments and wraps from TICK_DIV-1 to 0.
  - PAUSE and DONE: tdiv holds, so the fractional tick is kept across pause/resume.
  - cnt_en = running && tdiv==TICK_DIV-1 && !terminal. It is combinational from registered state, and at most 1 cycle wide.
  - When terminal is reached, no further cnt_en is issued. The count never passes 99.99 or 00.00.
- Scan prescaler:
  - Free-running counter 0..SCAN_DIV-1, running in all states.
  - At each wrap, scan_sel steps 0->3->2->1->0.
- Simultaneous events:
  - R and P together: R wins, state goes to CLEAR, and the P pulse is dropped.
  - Terminal condition and p_pulse in the same RUN cycle: go to PAUSE. Terminal is re-evaluated on resume, so the FSM reaches DONE on the first RUN cycle after resume.
- Latency:
  - A clean P rise reaches p_pulse 2 edges after it is first sampled.
  - The state changes on the 3rd edge.
  - R takes the same path, so cnt_clr asserts on the 3rd edge.

Test Plan:
- Bench uses TICK_DIV=4, SCAN_DIV=2.
1. Release R_n with sel=0, then pulse P for 3 cycles. Required: running=1 on the 3rd edge after P is sampled; cnt_en high 1 cycle in every 4; cnt_clr=0.
2. Pulse P again after 2 ticks with tdiv=1, then pulse P again. Required: PAUSE with cnt_en=0 and tdiv held at its PAUSE-entry value; after resume, the first cnt_en comes TICK_DIV-1-tdiv cycles later.
3. mode=0, drive C=16'h9999 in RUN. Required: cnt_en stays 0 in that cycle, DONE on the next edge (done=1), and P pulses are then ignored.
4. sel=3, load=8'h25 in CLEAR, start, change sel to 0 mid-run. Required: mode stays 3 and load_q stays 8'h25; C=16'h0000 leads to DONE.
5. Assert R and P together in RUN. Required: CLEAR with cnt_clr=1, not PAUSE; assert R_n mid-RUN, then all outputs take their reset values immediately, without waiting for a clock edge.
6. Over 16 cycles, scan_sel follows 0,0,3,3,2,2,1,1,0,... regardless of FSM state.
